// File: rtl/simple_cpu_pkg.sv
// Shared types and field positions for simple_cpu.
// Opcodes, ALU function codes and FSM states.
package simple_cpu_pkg;

  localparam int NUM_REGS = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } opcode_e;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_OR  = 4'd3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
  } state_e;

  localparam int OP_HI  = 19;
  localparam int OP_LO  = 18;
  localparam int X1_HI  = 17;
  localparam int X1_LO  = 16;
  localparam int X2_HI  = 15;
  localparam int X2_LO  = 14;
  localparam int X3_HI  = 13;
  localparam int X3_LO  = 12;
  localparam int OFF_HI = 11;
  localparam int OFF_LO = 4;
  localparam int FN_HI  = 3;
  localparam int FN_LO  = 0;

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational ALU for simple_cpu.
// ok is low for unsupported function codes.
module simple_cpu_alu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            funct,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  ok
);

  always_comb begin
    y  = '0;
    ok = 1'b1;
    unique case (1'b1)
      (funct == F_ADD): y = a + b;
      (funct == F_SUB): y = a - b;
      (funct == F_AND): y = a & b;
      (funct == F_OR):  y = a | b;
      default:          ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/simple_cpu.sv
// Multi-cycle teaching core: fetch/execute/writeback
// over a 4-entry register file and small data memory.
module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input logic                   clk,
  input logic                   rst,
  input logic [INSTR_WIDTH-1:0] instruction
);

  localparam int DEPTH = 1 << ADDR_BITS;

  state_e state;
  state_e state_n;

  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]  regfile  [NUM_REGS];
  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  result;
  logic [DATA_WIDTH-1:0]  mdr;
  logic                   res_ok;
  logic [ADDR_BITS-1:0]   eff_addr;

  opcode_e               op;
  logic [1:0]            x1;
  logic [1:0]            x2;
  logic [1:0]            x3;
  logic [7:0]            off;
  logic [3:0]            funct;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  alu_ok;
  logic [ADDR_BITS-1:0]  addr_n;

  assign op    = opcode_e'(ir[OP_HI:OP_LO]);
  assign x1    = ir[X1_HI:X1_LO];
  assign x2    = ir[X2_HI:X2_LO];
  assign x3    = ir[X3_HI:X3_LO];
  assign off   = ir[OFF_HI:OFF_LO];
  assign funct = ir[FN_HI:FN_LO];

  // Truncating each term first gives the same mod-2^ADDR_BITS sum.
  assign addr_n = ADDR_BITS'(regfile[x2])
                + ADDR_BITS'(off);

  simple_cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a    (regfile[x2]),
    .b    (regfile[x3]),
    .funct(funct),
    .y    (alu_y),
    .ok   (alu_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    unique case (state)
      S_FETCH: state_n = S_EXEC;
      S_EXEC:  state_n = S_WB;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      result   <= '0;
      mdr      <= '0;
      res_ok   <= 1'b0;
      eff_addr <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regfile[i] <= DATA_WIDTH'(i);
      for (int i = 0; i < DEPTH; i++)
        data_mem[i] <= '0;
    end else begin
      unique case (state)
        S_FETCH: ir <= instruction;
        S_EXEC: begin
          result   <= alu_y;
          res_ok   <= alu_ok;
          eff_addr <= addr_n;
          mdr      <= data_mem[addr_n];
        end
        S_WB: begin
          unique case (op)
            OP_ALU:
              if (res_ok) regfile[x1] <= result;
            OP_LOAD:  regfile[x1] <= mdr;
            OP_STORE: data_mem[eff_addr] <= regfile[x1];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// Directed bench for simple_cpu: vector table plus
// hand sequences for latency, reset abort and wrap.
module tb_simple_cpu;

  logic        clk;
  logic        rst;
  logic [19:0] instruction;

  int total;
  int passed;

  simple_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    bit          is_mem;
    int          idx;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  task automatic run(input logic [19:0] ins);
    instruction = ins;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    int bad;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_r%0d", tag, i),
          32'(dut.regfile[i]), i);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.data_mem[i] !== 8'h00) bad++;
    chk({tag, "_mem_zero"}, bad, 0);
    chk({tag, "_state"}, 32'(dut.state), 0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    instruction = '0;

    vecs[0]  = '{20'h00000, 0, 0,  8'h00, "nop_r0"};
    vecs[1]  = '{20'h47000, 0, 0,  8'h04, "add_r0"};
    vecs[2]  = '{20'h53000, 0, 1,  8'h07, "add_r1"};
    vecs[3]  = '{20'h72001, 0, 3,  8'h02, "sub_r3"};
    vecs[4]  = '{20'hD80F0, 1, 17, 8'h07, "st_m17"};
    vecs[5]  = '{20'hCC160, 1, 24, 8'h04, "st_m24"};
    vecs[6]  = '{20'hB80F0, 0, 3,  8'h07, "ld_r3"};
    vecs[7]  = '{20'h61002, 0, 2,  8'h04, "and_r2"};
    vecs[8]  = '{20'h69001, 0, 2,  8'hFD, "sub_wrap_r2"};
    vecs[9]  = '{20'h59002, 0, 1,  8'h05, "and_r1"};
    vecs[10] = '{20'h46003, 0, 0,  8'hFD, "or_r0"};
    vecs[11] = '{20'h71005, 0, 3,  8'h07, "bad_funct_r3"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst");

    foreach (vecs[k]) begin
      run(vecs[k].instr);
      if (vecs[k].is_mem)
        chk(vecs[k].name,
            32'(dut.data_mem[vecs[k].idx]),
            32'(vecs[k].exp));
      else
        chk(vecs[k].name,
            32'(dut.regfile[vecs[k].idx]),
            32'(vecs[k].exp));
      chk({vecs[k].name, "_state"},
          32'(dut.state), 0);
    end

    // load r3 <= mem[r1+0x13]; instruction changes after fetch
    instruction = 20'hB4130;
    @(posedge clk);
    @(negedge clk);
    instruction = 20'h4F000;
    chk("ld_after_fetch", 32'(dut.regfile[3]), 32'h07);
    @(posedge clk);
    @(negedge clk);
    chk("ld_after_exec", 32'(dut.regfile[3]), 32'h07);
    @(posedge clk);
    @(negedge clk);
    chk("ld_after_wb", 32'(dut.regfile[3]), 32'h04);
    chk("ld_r0_kept", 32'(dut.regfile[0]), 32'hFD);
    chk("ld_state", 32'(dut.state), 0);

    // reset lands on the execute edge of an add
    instruction = 20'h47000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    instruction = '0;
    chk_reset("abort");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_wb", 32'(dut.regfile[0]), 32'h00);
    @(posedge clk);
    @(negedge clk);

    // address wrap: r3(3) + 0xFF -> 2
    run(20'hDCFF0);
    chk("st_wrap_m2", 32'(dut.data_mem[2]), 32'h01);
    run(20'h8CFF0);
    chk("ld_wrap_r0", 32'(dut.regfile[0]), 32'h01);
    run(20'h76001);
    chk("sub_wrap_r3", 32'(dut.regfile[3]), 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simple_cpu.md
Name: simple_cpu

Overview:
- Minimal multi-cycle CPU core: 4-entry register file, small ALU and on-chip data memory.
- Executes one externally supplied instruction word per 3-clock FETCH/EXECUTE/WRITEBACK sequence. There is no program counter or instruction memory; the environment drives `instruction`.
- Used as a teaching/bring-up core. All state is internal and verified by hierarchical access to `regfile`, `data_mem` and `state`.

Parameters:
- DATA_WIDTH, 8, width of registers, data memory words and ALU.
- ADDR_BITS, 5, data memory address width; memory depth is 2**ADDR_BITS (32).
- INSTR_WIDTH, 20, instruction word width. The field layout below assumes 20.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instruction  input  INSTR_WIDTH  instruction word, sampled into IR in FETCH.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - regfile[0..3] = 0,1,2,3.
  - data_mem all 0.
  - IR = 0; state = FETCH.
- Instruction fields (of IR):
  - [19:18] opcode: 00 NOP, 01 ALU (R-type), 10 LOAD_R, 11 STORE_R.
  - [17:16] X1: ALU destination / LOAD destination / STORE source.
  - [15:14] X2: ALU operand A / memory base register.
  - [13:12] X3: ALU operand B.
  - [11:4] OFFSET: 8-bit unsigned immediate.
  - [3:0] FUNCT: 0 ADD, 1 SUB, 2 AND, 3 OR; any other FUNCT executes as NOP.
- FSM is free-running, 3 states, one edge each: FETCH -> EXECUTE -> WRITEBACK -> FETCH.
  - FETCH: IR <= instruction.
  - EXECUTE:
    - ALU: result <= regfile[X2] op regfile[X3]. ADD/SUB wrap modulo 2**DATA_WIDTH; no flags.
    - LOAD/STORE: eff_addr <= (regfile[X2] + zero-extended OFFSET) truncated to ADDR_BITS bits, so wrap-around is intended.
    - LOAD: mdr <= data_mem[eff_addr].
  - WRITEBACK:
    - ALU: regfile[X1] <= result.
    - LOAD: regfile[X1] <= mdr.
    - STORE: data_mem[eff_addr] <= regfile[X1].
    - NOP: no write.
- Latency: an instruction sampled at a FETCH edge takes effect at the WRITEBACK edge 2 cycles later. `instruction` may change freely after FETCH without affecting that instruction.
- Operands are read in EXECUTE, after the previous instruction's WRITEBACK, so there are no hazards.
- rst asserted mid-sequence aborts the instruction in flight: no writeback occurs, all state is reset, and FETCH is the next state.
- The first rising edge after reset release is a FETCH.

Decomposition:
- Package simple_cpu_pkg holds:
  - opcode enum (OP_NOP, OP_ALU, OP_LOAD, OP_STORE)
  - FUNCT constants
  - state enum (S_FETCH, S_EXEC, S_WB)
  - field bit-position localparams
  - NUM_REGS = 4
- One sub-module, simple_cpu_alu: combinational, two DATA_WIDTH operands plus FUNCT, produces the result and a valid flag (low for unsupported FUNCT).
- Register file, data memory and FSM stay in simple_cpu.

Test Plan:
- Reset, then drive instruction 0 for one sequence -> regfile = {0,1,2,3}, data_mem all 0, and state returns to FETCH every 3 edges.
- ADD 20'b01_00_01_11_00000000_0000 (r0 = r1+r3), then ADD 20'b01_01_00_11_..._0000 (r1 = r0+r3) -> r0=4, then r1=7.
- SUB 20'b01_11_00_10_00000000_0001 (r3 = r0-r2) -> r3=2. Then SUB with r0=0, r3=1 -> result 8'hFF (wrap).
- STORE 20'b11_01_10_00_00001111_0000 -> data_mem[17]=7. Then STORE 20'b11_00_11_00_00010110_0000 -> data_mem[24]=4.
- LOAD 20'b10_11_10_00_00001111_0000 -> r3=7 at its WRITEBACK edge and not before. Address wrap: base 3 + OFFSET 8'hFF -> address 2 (mod 32).
- Assert rst during EXECUTE of an ADD -> no register write; regfile back to {0,1,2,3}.
